// File: rtl/msg_block_buffer.sv
// msg_block_buffer
// Packs the upstream message byte stream into 64-byte BLAKE2s blocks.
// Two banks alternate, so one block can fill while the compression core
// drains the other. Each bank latches its own t (bytes consumed through the
// end of that block) and its final-block flag. Bytes that are never written
// read as zero, which gives the zero padding of the final block.
module msg_block_buffer #(
  parameter int BLK_BYTES = 64,
  parameter int T_W       = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_v_i,
  input  logic [7:0]             data_i,
  input  logic [5:0]             data_idx_i,
  input  logic                   block_first_i,
  input  logic                   block_last_i,
  output logic                   blk_v_o,
  input  logic                   blk_ready_i,
  output logic [8*BLK_BYTES-1:0] blk_o,
  output logic [T_W-1:0]         t_o,
  output logic                   last_o,
  output logic                   err_o
);

  localparam int BLK_W = 8 * BLK_BYTES;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Registered bank state
  bank_state_t      bank_state_r [2];
  logic [BLK_W-1:0] bank_data_r  [2];
  logic [6:0]       bank_cnt_r   [2];
  logic [T_W-1:0]   bank_t_r     [2];
  logic             bank_last_r  [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [T_W-1:0]   run_t_r;

  // Next-state values
  bank_state_t      bank_state_s [2];
  logic [BLK_W-1:0] bank_data_s  [2];
  logic [6:0]       bank_cnt_s   [2];
  logic [T_W-1:0]   bank_t_s     [2];
  logic             bank_last_s  [2];
  logic             wr_ptr_s;
  logic             rd_ptr_s;
  logic [T_W-1:0]   run_t_s;
  logic             err_s;

  // Working values of the write path
  logic             xfer_s;
  logic             fresh_s;
  logic [6:0]       cur_cnt_s;
  logic [6:0]       new_cnt_s;
  logic [T_W-1:0]   base_t_s;
  logic [T_W-1:0]   close_t_s;

  // Next-state logic: read-side transfer, byte write, block close, errors
  always_comb begin
    bank_state_s = bank_state_r;
    bank_data_s  = bank_data_r;
    bank_cnt_s   = bank_cnt_r;
    bank_t_s     = bank_t_r;
    bank_last_s  = bank_last_r;
    wr_ptr_s     = wr_ptr_r;
    rd_ptr_s     = rd_ptr_r;
    run_t_s      = run_t_r;
    err_s        = err_o;
    fresh_s      = 1'b0;
    cur_cnt_s    = bank_cnt_r[wr_ptr_r];
    new_cnt_s    = {1'b0, data_idx_i} + 7'd1;
    base_t_s     = run_t_r;
    close_t_s    = run_t_r;

    // The read bank is handed to the core whenever it is full and accepted.
    xfer_s = (bank_state_r[rd_ptr_r] == BANK_FULL) && blk_ready_i;
    if (xfer_s) begin
      bank_state_s[rd_ptr_r] = BANK_EMPTY;
      rd_ptr_s               = ~rd_ptr_r;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    // The write bank can only be FULL when both banks are FULL; the transfer
    // happening this same cycle does not make room for this byte.
    if (data_v_i) begin
      if (bank_state_r[wr_ptr_r] == BANK_FULL) begin
        err_s = 1'b1;
      end else begin
        if (block_first_i) begin
          // A new message restarts t and throws away any partial block.
          base_t_s = {T_W{1'b0}};
          fresh_s  = 1'b1;
          if (data_idx_i != 6'd0) begin
            err_s = 1'b1;
          end else begin
            err_s = err_s;
          end
        end else begin
          fresh_s = (bank_state_r[wr_ptr_r] == BANK_EMPTY);
        end

        if (fresh_s) begin
          cur_cnt_s               = 7'd0;
          bank_data_s[wr_ptr_r]   = {BLK_W{1'b0}};
        end else begin
          cur_cnt_s = bank_cnt_r[wr_ptr_r];
        end

        // Out-of-order index is flagged but the byte is still stored.
        if ({1'b0, data_idx_i} != cur_cnt_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end

        bank_data_s[wr_ptr_r][{data_idx_i, 3'b000} +: 8] = data_i;
        bank_cnt_s[wr_ptr_r] = new_cnt_s;
        close_t_s            = base_t_s + {{(T_W-7){1'b0}}, new_cnt_s};

        if ((data_idx_i == 6'd63) || block_last_i) begin
          bank_state_s[wr_ptr_r] = BANK_FULL;
          bank_t_s[wr_ptr_r]     = close_t_s;
          bank_last_s[wr_ptr_r]  = block_last_i;
          wr_ptr_s               = ~wr_ptr_r;
          run_t_s                = close_t_s;
        end else begin
          bank_state_s[wr_ptr_r] = BANK_FILLING;
          run_t_s                = base_t_s;
        end
      end
    end else begin
      err_s = err_s;
    end
  end

  // Bank and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_r[b] <= BANK_EMPTY;
        bank_data_r[b]  <= {BLK_W{1'b0}};
        bank_cnt_r[b]   <= 7'd0;
        bank_t_r[b]     <= {T_W{1'b0}};
        bank_last_r[b]  <= 1'b0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      run_t_r  <= {T_W{1'b0}};
    end else begin
      bank_state_r <= bank_state_s;
      bank_data_r  <= bank_data_s;
      bank_cnt_r   <= bank_cnt_s;
      bank_t_r     <= bank_t_s;
      bank_last_r  <= bank_last_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      run_t_r      <= run_t_s;
    end
  end

  // Output registers, loaded from the next read bank so they track bank state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_v_o <= 1'b0;
      blk_o   <= {BLK_W{1'b0}};
      t_o     <= {T_W{1'b0}};
      last_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      blk_v_o <= (bank_state_s[rd_ptr_s] == BANK_FULL);
      blk_o   <= bank_data_s[rd_ptr_s];
      t_o     <= bank_t_s[rd_ptr_s];
      last_o  <= bank_last_s[rd_ptr_s];
      err_o   <= err_s;
    end
  end

endmodule

// File: doc/msg_block_buffer.md
Name: msg_block_buffer

Overview:
- Sits directly downstream of the I/O interface byte stream and upstream of the BLAKE2s compression core.
- Packs incoming message bytes into 64-byte (16 x 32-bit little-endian word) blocks and zero-pads the final block.
- Tracks the byte offset counter t and the final-block flag f.
- Double-buffers two banks so one block can fill while the compression core consumes the other.

Parameters:
- BLK_BYTES, 64, bytes per block; fixed, not meant to be overridden.
- T_W, 64, width of the byte offset counter t.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- data_v_i  in  1  byte valid; no backpressure toward upstream
- data_i  in  8  message byte
- data_idx_i  in  6  byte position within current block, 0..63
- block_first_i  in  1  with data_v_i: byte is first byte of a new message
- block_last_i  in  1  with data_v_i: byte is final byte of the message
- blk_v_o  out  1  a block is available to the core
- blk_ready_i  in  1  core accepts block
- blk_o  out  512  block data; byte k at bits [8k+7:8k]
- t_o  out  64  bytes of message consumed up to and including this block
- last_o  out  1  block is the final block (BLAKE2 f0)
- err_o  out  1  sticky protocol error

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: blk_v_o=0, last_o=0, t_o=0, err_o=0, blk_o=0. Both banks are empty and the write pointer is bank 0.
- Bank state is one of EMPTY, FILLING, FULL.
- Write side:
  - A byte with data_v_i=1 is written to the write bank at data_idx_i.
  - The bank's byte count becomes data_idx_i+1.
  - The first write to an EMPTY bank clears all 64 bytes of that bank to zero in the same cycle. Bytes not written read as 0.
- Block close:
  - The write bank closes (FULL) on the cycle after a byte with data_idx_i==63 or block_last_i==1.
  - On close, the bank latches t = running_t + count and last = block_last_i.
  - The write pointer then toggles.
  - running_t (T_W bits, wraps modulo 2^64) updates to the latched t.
- block_first_i==1:
  - Clears running_t to 0 before the byte is counted.
  - Discards any FILLING bank, which returns to EMPTY and is reused for this byte.
  - FULL banks are unaffected.
- Read side:
  - blk_v_o=1 whenever the read bank is FULL.
  - blk_o, t_o and last_o come from the read bank and hold stable while blk_v_o=1 and blk_ready_i=0.
  - A transfer occurs when blk_v_o and blk_ready_i are both 1. On that cycle the bank becomes EMPTY and the read pointer toggles.
  - blk_v_o may stay high on the next cycle if the other bank is FULL.
- Latency: the byte closing a block lands in cycle N; blk_v_o rises in N+1 if the read side is idle.
- Simultaneous events:
  - A transfer out of bank A and a write into bank B in the same cycle are both honoured.
  - A transfer freeing bank A and the closing of bank B in the same cycle leaves B as the new read bank, valid the next cycle.
- Error conditions (err_o set, sticky until reset):
  - data_v_i while both banks are FULL: the byte is dropped and bank contents are unchanged.
  - data_idx_i != current bank count: the byte is still written.
  - block_first_i with data_idx_i != 0.
- Reset asserted mid-operation: all banks go EMPTY, blk_v_o drops combinationally-free. Outputs are registered, and reset clears them asynchronously.
- Empty message (zero bytes, no key) is out of scope. It is signalled upstream as a single zero byte with first=last=1 and handled by the control FSM.
- Size: two 512-bit banks plus control, approximately 200 RTL lines.

Test Plan:
- 3-byte message 0x61,0x62,0x63, first on idx0, last on idx2, blk_ready_i=1 -> one block:
  - blk_o[23:0]=0x636261, remaining bits 0
  - t_o=3, last_o=1, blk_v_o high exactly 1 cycle.
- 130-byte message, blk_ready_i=1 -> three blocks:
  - t_o = 64, 128, 130
  - last_o = 0, 0, 1
  - third block has 2 data bytes and 62 zero bytes.
- blk_ready_i=0 held while 128 bytes stream, then a 129th byte arrives -> blk_v_o=1 and err_o=1. First block remains unchanged after ready is raised, with t_o=64.
- blk_ready_i pulsed in the same cycle that byte idx63 of the second block is written -> no error; both blocks delivered in order with t_o=64 then 128.
- block_first_i reasserted after 10 bytes of a message -> the partial bank is discarded. The next delivered block has t_o equal to the count from the new start only.
- Reset asserted while one bank is FULL and blk_ready_i=0 -> blk_v_o=0 and t_o=0. The next message delivers normally with err_o=0.
